// File: rtl/truth_table_checker.sv
// Exhaustive truth-table sweeper: drives every input vector in ascending order, holds it
// SETTLE+1 cycles, compares dut_y against EXP_TABLE and records mismatch statistics.
module truth_table_checker #(
  parameter int unsigned           N_IN      = 4,
  parameter logic [(2**N_IN)-1:0]  EXP_TABLE = '0,
  parameter int unsigned           SETTLE    = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            dut_y,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            first_fail_valid,
  output logic [N_IN-1:0] first_fail_idx
);

  localparam logic [3:0]      SettleLast = 4'(SETTLE);
  localparam logic [N_IN-1:0] StimOne    = N_IN'(1);
  localparam logic [N_IN:0]   ErrOne     = (N_IN + 1)'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic [3:0]      settle_q, settle_d;
  logic [N_IN:0]   err_q, err_d;
  logic            ffv_q, ffv_d;
  logic [N_IN-1:0] ffi_q, ffi_d;

  logic sample, mismatch, last_vec;

  always_comb begin
    state_d  = state_q;
    stim_d   = stim_q;
    settle_d = settle_q;
    err_d    = err_q;
    ffv_d    = ffv_q;
    ffi_d    = ffi_q;

    sample   = (settle_q == SettleLast);
    mismatch = (dut_y != EXP_TABLE[stim_q]);
    last_vec = &stim_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StRun;
          stim_d   = '0;
          settle_d = '0;
          err_d    = '0;
          ffv_d    = 1'b0;
          ffi_d    = '0;
        end
      end
      StRun: begin
        if (!sample) begin
          settle_d = settle_q + 4'd1;
        end else begin
          settle_d = '0;
          if (mismatch) begin
            err_d = err_q + ErrOne;
            if (!ffv_q) begin
              ffv_d = 1'b1;
              ffi_d = stim_q;
            end
          end
          // Last vector wraps stim back to 0 so DONE presents an idle bus to the DUT.
          if (last_vec) begin
            stim_d  = '0;
            state_d = StDone;
          end else begin
            stim_d = stim_q + StimOne;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      stim_q   <= '0;
      settle_q <= '0;
      err_q    <= '0;
      ffv_q    <= 1'b0;
      ffi_q    <= '0;
    end else begin
      state_q  <= state_d;
      stim_q   <= stim_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      ffv_q    <= ffv_d;
      ffi_q    <= ffi_d;
    end
  end

  assign stim             = stim_q;
  assign busy             = (state_q == StRun);
  assign done             = (state_q == StDone);
  assign pass             = (state_q == StDone) && (err_q == '0);
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_idx   = ffi_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: two instances (SETTLE=1 and SETTLE=0) checked each cycle
// against a sweep-level model, plus literal expectations for each directed scenario.
module tb_truth_table_checker;

  localparam logic [15:0] ExpTable = 16'hA5A5;

  // DUT response modes
  localparam int ModeGolden = 0;
  localparam int ModeStuck0 = 1;
  localparam int ModeStuck1 = 2;
  localparam int ModeFlip9  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start [2];
  logic       dut_y [2];
  logic [3:0] stim [2];
  logic       busy [2];
  logic       done [2];
  logic       pass [2];
  logic [4:0] err_count [2];
  logic       ffv [2];
  logic [3:0] ffi [2];

  int mode [2];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  truth_table_checker #(.N_IN(4), .EXP_TABLE(ExpTable), .SETTLE(1)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .dut_y(dut_y[0]), .stim(stim[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err_count[0]),
    .first_fail_valid(ffv[0]), .first_fail_idx(ffi[0])
  );

  truth_table_checker #(.N_IN(4), .EXP_TABLE(ExpTable), .SETTLE(0)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .dut_y(dut_y[1]), .stim(stim[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err_count[1]),
    .first_fail_valid(ffv[1]), .first_fail_idx(ffi[1])
  );

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  function automatic bit exp_bit(input int v);
    logic [15:0] t;
    t = ExpTable;
    return t[v];
  endfunction

  function automatic bit y_of(input int m, input int v);
    case (m)
      ModeStuck0: return 1'b0;
      ModeStuck1: return 1'b1;
      ModeFlip9:  return (v == 9) ? !exp_bit(v) : exp_bit(v);
      default:    return exp_bit(v);
    endcase
  endfunction

  assign dut_y[0] = y_of(mode[0], int'(stim[0]));
  assign dut_y[1] = y_of(mode[1], int'(stim[1]));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sweep-level model: phase 0 idle, 1 run (k = cycles since start accepted), 2 done.
  int phase [2] = '{0, 0};
  int k [2]     = '{0, 0};
  int smode [2] = '{0, 0};

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        phase[i] = 0;
      end else begin
        case (phase[i])
          1: begin
            k[i]++;
            if (k[i] == 16 * (settle_of(i) + 1)) phase[i] = 2;
          end
          default: if (start[i]) begin
            phase[i] = 1;
            k[i]     = 0;
            smode[i] = mode[i];
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int nv, estim, ee, efi;
      bit efv;
      // Vectors whose sample edge has already passed
      nv    = (phase[i] == 1) ? k[i] / (settle_of(i) + 1) : ((phase[i] == 2) ? 16 : 0);
      estim = (phase[i] == 1) ? nv : 0;
      ee = 0; efv = 1'b0; efi = 0;
      for (int v = 0; v < nv; v++) begin
        if (y_of(smode[i], v) != exp_bit(v)) begin
          ee++;
          if (!efv) begin efv = 1'b1; efi = v; end
        end
      end
      chk($sformatf("u%0d.stim", i), int'(stim[i]), estim);
      chk($sformatf("u%0d.busy", i), int'(busy[i]), int'(phase[i] == 1));
      chk($sformatf("u%0d.done", i), int'(done[i]), int'(phase[i] == 2));
      chk($sformatf("u%0d.pass", i), int'(pass[i]), int'(phase[i] == 2 && ee == 0));
      chk($sformatf("u%0d.err_count", i), int'(err_count[i]), ee);
      chk($sformatf("u%0d.first_fail_valid", i), int'(ffv[i]), int'(efv));
      chk($sformatf("u%0d.first_fail_idx", i), int'(ffi[i]), efi);
    end
  end

  // Pulse start, optionally pulse it again at cycle `inject`, count cycles until done.
  task automatic run_sweep(input int i, input int inject, output int cyc);
    @(negedge clk); start[i] = 1'b1;
    @(negedge clk); start[i] = 1'b0;
    cyc = 0;
    while (!done[i] && cyc < 200) begin
      if (cyc == inject) start[i] = 1'b1;
      @(negedge clk);
      start[i] = 1'b0;
      cyc++;
    end
  endtask

  task automatic chk_results(input string tag, input int i, input int e_err, input int e_ffv,
                             input int e_ffi, input int e_pass);
    chk({tag, ".err_count"}, int'(err_count[i]), e_err);
    chk({tag, ".first_fail_valid"}, int'(ffv[i]), e_ffv);
    chk({tag, ".first_fail_idx"}, int'(ffi[i]), e_ffi);
    chk({tag, ".pass"}, int'(pass[i]), e_pass);
  endtask

  initial begin
    int cyc;
    start[0] = 1'b0; start[1] = 1'b0;
    mode[0] = ModeGolden; mode[1] = ModeGolden;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    chk("reset.u0.stim", int'(stim[0]), 0);
    chk("reset.u0.done", int'(done[0]), 0);
    chk("reset.u1.busy", int'(busy[1]), 0);

    run_sweep(0, -1, cyc);
    chk("golden.cycles", cyc, 32);
    chk_results("golden", 0, 0, 0, 0, 1);

    mode[0] = ModeStuck0;
    run_sweep(0, -1, cyc);
    chk("stuck0.cycles", cyc, 32);
    chk_results("stuck0", 0, 8, 1, 0, 0);

    mode[0] = ModeStuck1;
    run_sweep(0, -1, cyc);
    chk_results("stuck1", 0, 8, 1, 1, 0);
    repeat (3) @(negedge clk);
    chk("stuck1.hold.err_count", int'(err_count[0]), 8);

    // Restart from a failing DONE with a start pulse injected mid-run
    mode[0] = ModeGolden;
    run_sweep(0, 10, cyc);
    chk("restart.cycles", cyc, 32);
    chk_results("restart", 0, 0, 0, 0, 1);

    mode[1] = ModeFlip9;
    run_sweep(1, -1, cyc);
    chk("flip9.cycles", cyc, 16);
    chk_results("flip9", 1, 1, 1, 9, 0);

    mode[1] = ModeStuck1;
    run_sweep(1, -1, cyc);
    chk_results("s0_stuck1", 1, 8, 1, 1, 0);

    // Reset mid-sweep once stim reaches 5
    mode[0] = ModeStuck0;
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    cyc = 0;
    while (stim[0] != 4'd5 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("midreset.reached_stim5", int'(stim[0] == 4'd5), 1);
    #1 rst = 1'b1;
    #1;
    chk("midreset.stim", int'(stim[0]), 0);
    chk("midreset.busy", int'(busy[0]), 0);
    chk("midreset.done", int'(done[0]), 0);
    chk("midreset.pass", int'(pass[0]), 0);
    chk("midreset.err_count", int'(err_count[0]), 0);
    chk("midreset.first_fail_valid", int'(ffv[0]), 0);
    chk("midreset.first_fail_idx", int'(ffi[0]), 0);
    chk("midreset.u1.done", int'(done[1]), 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    mode[0] = ModeGolden;
    run_sweep(0, -1, cyc);
    chk("postreset.cycles", cyc, 32);
    chk_results("postreset", 0, 0, 0, 0, 1);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
